uart_rx: RTL and testbench

- Serial receiver for the UART link. Recovers frames of 1 start bit, in_width data bits (LSB first), an optional parity bit and 1 stop bit.
- Uses an oversampling clock with a runtime prescale and takes a 3-sample majority vote at mid-bit.
- Outputs the received parallel word with a one-cycle valid pulse, plus parity and framing error flags.
- Sits at the far end of the serial line from the transmitter and shares its parity_EN/parity_type conventions.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/rx_data_sampling.sv | 62 ++++++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
//   rx_state_e      : receiver FSM states
//   PAR_EVEN/PAR_ODD: parity_type encodings (same as the transmitter)
//   SMP_*/VOTE_OFS  : sample positions around the bit midpoint P/2
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Samples at P/2-1, P/2, P/2+1; vote registered at P/2+2.
  localparam int unsigned SMP_EARLY_OFS = 1;
  localparam int unsigned SMP_LATE_OFS  = 1;
  localparam int unsigned VOTE_OFS      = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_data_sampling.sv
// Oversampling bit timer and 3-sample majority voter.
//   clk, rst     : clock, synchronous active-high reset
//   en           : count enable (frame in progress or start edge seen)
//   rx_s         : synchronized serial line
//   prescale     : oversampling ratio P
//   sampled_bit  : majority of the three mid-bit samples, valid from P/2+3
//   bit_tick     : high in the cycle where edge_cnt == P-1
module rx_data_sampling
  import uart_rx_pkg::*;
#(
  parameter int unsigned prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      rx_s,
  input  logic [prescale_width-1:0] prescale,
  output logic                      sampled_bit,
  output logic                      bit_tick
);

  localparam int unsigned PW = prescale_width;

  logic [PW-1:0] edge_cnt;
  logic [PW-1:0] edge_nxt;
  logic [PW-1:0] half;
  logic          smp_early;
  logic          smp_mid;
  logic          smp_late;

  assign half = prescale >> 1;

  // Edge counter wraps at P-1 and sits at 0 whenever disabled.
  always_comb begin
    edge_nxt = '0;
    if (en && (edge_cnt != prescale - PW'(1))) begin
      edge_nxt = edge_cnt + PW'(1);
    end
  end

  // bit_tick is decoded from edge_nxt so it lines up with edge_cnt == P-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt    <= '0;
      bit_tick    <= 1'b0;
      smp_early   <= 1'b1;
      smp_mid     <= 1'b1;
      smp_late    <= 1'b1;
      sampled_bit <= 1'b1;
    end else begin
      edge_cnt <= edge_nxt;
      bit_tick <= (edge_nxt == prescale - PW'(1));
      if (edge_cnt == half - PW'(SMP_EARLY_OFS)) smp_early <= rx_s;
      if (edge_cnt == half)                      smp_mid   <= rx_s;
      if (edge_cnt == half + PW'(SMP_LATE_OFS))  smp_late  <= rx_s;
      if (edge_cnt == half + PW'(VOTE_OFS)) begin
        sampled_bit <= majority3(smp_early, smp_mid, smp_late);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, in_width data bits LSB first, optional parity, stop.
//   clk, rst     : clock, synchronous active-high reset
//   RX_IN        : asynchronous serial line, idle high
//   prescale     : oversampling ratio (8, 16 or 32)
//   parity_EN    : frame carries a parity bit
//   parity_type  : PAR_EVEN / PAR_ODD
//   P_DATA       : last correctly received word
//   data_valid   : one-cycle pulse when P_DATA updates
//   parity_error : one-cycle pulse at end of a frame with bad parity
//   stop_error   : one-cycle pulse at end of a frame whose stop bit was 0
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned in_width       = 8,
  parameter int unsigned prescale_width = 6,
  parameter int unsigned count_width    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_IN,
  input  logic [prescale_width-1:0] prescale,
  input  logic                      parity_EN,
  input  logic                      parity_type,
  output logic [in_width-1:0]       P_DATA,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      stop_error
);

  localparam logic [count_width-1:0] LAST_BIT = count_width'(in_width - 1);

  rx_state_e              state;
  rx_state_e              state_nxt;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   sampled_bit;
  logic                   bit_tick;
  logic                   cnt_en;
  logic [count_width-1:0] bit_cnt;
  logic [in_width-1:0]    shift_reg;
  logic                   par_err_q;
  logic                   exp_parity;
  logic                   dv_nxt;
  logic                   pe_nxt;
  logic                   se_nxt;

  // Two-flop synchronizer; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // The falling-edge cycle in IDLE already counts as edge 0.
  assign cnt_en = (state != IDLE) || !rx_s;

  rx_data_sampling #(
    .prescale_width(prescale_width)
  ) u_sampling (
    .clk        (clk),
    .rst        (rst),
    .en         (cnt_en),
    .rx_s       (rx_s),
    .prescale   (prescale),
    .sampled_bit(sampled_bit),
    .bit_tick   (bit_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START:  if (bit_tick) state_nxt = sampled_bit ? IDLE : DATA;
      DATA:   if (bit_tick && (bit_cnt == LAST_BIT)) state_nxt = parity_EN ? PARITY : STOP;
      PARITY: if (bit_tick) state_nxt = STOP;
      STOP:   if (bit_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame-end flags, registered below.
  always_comb begin
    dv_nxt = 1'b0;
    pe_nxt = 1'b0;
    se_nxt = 1'b0;
    if ((state == STOP) && bit_tick) begin
      pe_nxt = parity_EN & par_err_q;
      se_nxt = ~sampled_bit;
      dv_nxt = sampled_bit & ~(parity_EN & par_err_q);
    end
  end

  always_comb begin
    exp_parity = ^shift_reg;
    unique case (parity_type)
      PAR_EVEN: exp_parity = ^shift_reg;
      PAR_ODD:  exp_parity = ~(^shift_reg);
      default:  exp_parity = ^shift_reg;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_err_q    <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= dv_nxt;
      parity_error <= pe_nxt;
      stop_error   <= se_nxt;
      if (dv_nxt) P_DATA <= shift_reg;
      if (state == START) par_err_q <= 1'b0;
      if ((state == DATA) && bit_tick) begin
        shift_reg <= {sampled_bit, shift_reg[in_width-1:1]};
        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + count_width'(1);
      end
      if ((state == PARITY) && bit_tick) par_err_q <= sampled_bit ^ exp_parity;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned IW = 8;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          parity_EN = 1'b0;
  logic          parity_type = 1'b0;
  logic [IW-1:0] P_DATA;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;

  uart_rx #(.in_width(IW), .prescale_width(PW), .count_width(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX_IN       (RX_IN),
    .prescale    (prescale),
    .parity_EN   (parity_EN),
    .parity_type (parity_type),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .parity_error(parity_error),
    .stop_error  (stop_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Pulse logs: cycle of each pulse, plus the word seen with data_valid.
  int            dv_cyc[$];
  logic [IW-1:0] dv_dat[$];
  int            pe_cyc[$];
  int            se_cyc[$];

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(P_DATA);
    end
    if (parity_error) pe_cyc.push_back(cyc);
    if (stop_error)   se_cyc.push_back(cyc);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    dv_cyc.delete();
    dv_dat.delete();
    pe_cyc.delete();
    se_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting #1 after a clock edge; t_drive is the cycle of
  // the start-bit drive. gbit selects a frame bit whose midpoint sample is flipped.
  task automatic send_frame(input int p, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic sbit, input int gbit,
                            output int t_drive);
    logic [10:0] fr;
    int          n;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    if (pen) begin
      fr[9]  = pbit;
      fr[10] = sbit;
      n      = 11;
    end else begin
      fr[9] = sbit;
      n     = 10;
    end
    t_drive = cyc;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        RX_IN = ((k == gbit) && (c == p / 2)) ? ~fr[k] : fr[k];
        @(posedge clk);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  typedef struct {
    int           p;
    logic         pen;
    logic         ptype;
    logic [7:0]   d;
    logic         pbit;
    logic         sbit;
    int           gbit;
    logic         ev;
    logic         epe;
    logic         ese;
    logic [7:0]   epd;
  } vec_t;

  vec_t vt[8];

  initial begin
    int t;
    int t2;
    int n;
    int ef;
    string tag;

    // p, pen, ptype, data, parity bit, stop bit, glitch bit -> valid, perr, serr, P_DATA
    vt[0] = '{8,  1'b1, PAR_EVEN, 8'hA5, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[1] = '{8,  1'b1, PAR_ODD,  8'h01, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vt[2] = '{8,  1'b0, PAR_EVEN, 8'h55, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vt[3] = '{16, 1'b0, PAR_EVEN, 8'h3C, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h3C};
    vt[4] = '{32, 1'b1, PAR_ODD,  8'h0F, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h0F};
    vt[5] = '{8,  1'b1, PAR_EVEN, 8'h12, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b1, 8'h0F};
    vt[6] = '{16, 1'b0, PAR_EVEN, 8'h81, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 8'h81};
    vt[7] = '{16, 1'b1, PAR_EVEN, 8'hC3, 1'b0, 1'b1,  9, 1'b1, 1'b0, 1'b0, 8'hC3};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pdata", P_DATA, 0);
    check("rst_dv", data_valid, 0);
    check("rst_pe", parity_error, 0);
    check("rst_se", stop_error, 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    rst = 1'b0;
    idle(5);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      prescale    = PW'(vt[i].p);
      parity_EN   = vt[i].pen;
      parity_type = vt[i].ptype;
      idle(2);
      clear_logs();
      send_frame(vt[i].p, vt[i].d, vt[i].pen, vt[i].pbit, vt[i].sbit, vt[i].gbit, t);
      idle(10);
      n  = 10 + int'(vt[i].pen);
      ef = t + 2 + n * vt[i].p;
      tag = $sformatf("v%0d", i);
      check({tag, "_dv_cnt"}, dv_cyc.size(), int'(vt[i].ev));
      check({tag, "_pe_cnt"}, pe_cyc.size(), int'(vt[i].epe));
      check({tag, "_se_cnt"}, se_cyc.size(), int'(vt[i].ese));
      check({tag, "_pdata"}, P_DATA, vt[i].epd);
      if (dv_cyc.size() > 0) begin
        check({tag, "_dv_time"}, dv_cyc[0], ef);
        check({tag, "_dv_data"}, dv_dat[0], vt[i].d);
      end
      if (pe_cyc.size() > 0) check({tag, "_pe_time"}, pe_cyc[0], ef);
      if (se_cyc.size() > 0) check({tag, "_se_time"}, se_cyc[0], ef);
    end

    // Back-to-back frames with no idle gap.
    prescale  = PW'(16);
    parity_EN = 1'b0;
    idle(2);
    clear_logs();
    send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b1, -1, t);
    send_frame(16, 8'hFF, 1'b0, 1'b0, 1'b1, -1, t2);
    idle(10);
    check("b2b_dv_cnt", dv_cyc.size(), 2);
    check("b2b_err_cnt", pe_cyc.size() + se_cyc.size(), 0);
    if (dv_cyc.size() == 2) begin
      check("b2b_first_time", dv_cyc[0], t + 2 + 160);
      check("b2b_spacing", dv_cyc[1] - dv_cyc[0], 160);
      check("b2b_data0", dv_dat[0], 8'h3C);
      check("b2b_data1", dv_dat[1], 8'hFF);
    end

    // Three-cycle low glitch while idle: false start rejected.
    clear_logs();
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(40);
    check("glitch_dv_cnt", dv_cyc.size(), 0);
    check("glitch_err_cnt", pe_cyc.size() + se_cyc.size(), 0);
    check("glitch_state", int'(dut.state), int'(IDLE));
    check("glitch_pdata", P_DATA, 8'hFF);

    // Reset during the 4th data bit, then a clean frame.
    prescale = PW'(8);
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      RX_IN = (k == 0) ? 1'b0 : 1'b1;  // start, then bits 0..2 of 0x81 = 1,0,0
      if (k >= 2) RX_IN = 1'b0;
      idle(8);
    end
    RX_IN = 1'b0;
    idle(3);
    rst   = 1'b1;
    RX_IN = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_state", int'(dut.state), int'(IDLE));
    check("midrst_pdata", P_DATA, 0);
    check("midrst_dv", data_valid, 0);
    check("midrst_flags", {parity_error, stop_error}, 0);
    idle(100);
    check("midrst_no_pulse", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
    clear_logs();
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1, -1, t);
    idle(10);
    check("post_rst_dv_cnt", dv_cyc.size(), 1);
    check("post_rst_pdata", P_DATA, 8'h81);
    if (dv_cyc.size() > 0) check("post_rst_time", dv_cyc[0], t + 2 + 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
